// File: rtl/exec_pkg.sv
// exec_pkg: shared opcode/state encodings and width defaults for exec_unit.
package exec_pkg;
  localparam int DW_DEF = 8;
  localparam int AW_DEF = 2;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MOV = 3'b101,
    OP_MUL = 3'b110,
    OP_CMP = 3'b111
  } op_e;
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;
endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: iterative shift-add multiplier, one partial product per cycle over DW cycles.
module mul_shift_add
  import exec_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   a,
  input  logic [DW-1:0]   b,
  output logic            done,
  output logic [2*DW-1:0] product
);
  localparam int CW = $clog2(DW);
  logic [2*DW-1:0] acc_q, acc_d, mc_q, mc_d;
  logic [DW-1:0] mp_q, mp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  // product already includes the current iteration, so it is final when done is high
  assign product = acc_q + (mp_q[0] ? mc_q : '0);
  assign done = run_q && cnt_q == CW'(DW - 1);
  always_comb begin
    acc_d = acc_q;
    mc_d = mc_q;
    mp_d = mp_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start) begin
      acc_d = '0;
      mc_d = {{DW{1'b0}}, a};
      mp_d = b;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = product;
      mc_d = mc_q << 1;
      mp_d = mp_q >> 1;
      cnt_d = cnt_q + 1'b1;
      run_d = !done;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      mc_q <= '0;
      mp_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      mc_q <= mc_d;
      mp_q <= mp_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
endmodule

// File: rtl/exec_unit.sv
// exec_unit: single-issue ALU with registered write-back; the iterative multiplier
// is built only when EXEC_UNIT_MUL_EN is defined, otherwise opcode MUL is illegal.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue_valid,
  output logic          issue_ready,
  input  logic [2:0]    op,
  input  logic [AW-1:0] dst,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  output logic          carry,
  output logic          zero,
  output logic          busy,
  output logic          illegal
);
  state_e state_q, state_d;
  logic wb_en_q, wb_en_d, carry_q, carry_d, zero_q, zero_d, illegal_q, illegal_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d, res;
  logic [DW:0] sum, diff;
  logic accept, do_wb;
`ifdef EXEC_UNIT_MUL_EN
  logic [AW-1:0] mdst_q, mdst_d;
  logic mul_done;
  logic [2*DW-1:0] mul_prod;
  mul_shift_add #(.DW(DW)) u_mul (
    .clk(clk),
    .rst_n(rst_n),
    .start(accept && op == OP_MUL),
    .a(opa),
    .b(opb),
    .done(mul_done),
    .product(mul_prod)
  );
`endif
  assign issue_ready = state_q == ST_IDLE;
  assign busy = state_q == ST_MUL;
  assign accept = issue_valid && issue_ready;
  assign sum = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};
  assign wb_en = wb_en_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign carry = carry_q;
  assign zero = zero_q;
  assign illegal = illegal_q;
  always_comb begin
    state_d = state_q;
    wb_en_d = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    carry_d = carry_q;
    zero_d = zero_q;
    illegal_d = 1'b0;
    res = '0;
    do_wb = 1'b0;
`ifdef EXEC_UNIT_MUL_EN
    mdst_d = mdst_q;
`endif
    if (accept) begin
      case (op_e'(op))
        OP_ADD: begin res = sum[DW-1:0]; carry_d = sum[DW]; do_wb = 1'b1; end
        OP_SUB: begin res = diff[DW-1:0]; carry_d = diff[DW]; do_wb = 1'b1; end
        OP_AND: begin res = opa & opb; do_wb = 1'b1; end
        OP_OR:  begin res = opa | opb; do_wb = 1'b1; end
        OP_XOR: begin res = opa ^ opb; do_wb = 1'b1; end
        OP_MOV: begin res = opb; do_wb = 1'b1; end
        OP_CMP: begin zero_d = diff[DW-1:0] == '0; carry_d = diff[DW]; end
        OP_MUL: begin
`ifdef EXEC_UNIT_MUL_EN
          state_d = ST_MUL;
          mdst_d = dst;
`else
          illegal_d = 1'b1;
`endif
        end
      endcase
      if (do_wb) begin
        wb_en_d = 1'b1;
        wb_addr_d = dst;
        wb_data_d = res;
        zero_d = res == '0;
      end
    end
`ifdef EXEC_UNIT_MUL_EN
    if (state_q == ST_MUL && mul_done) begin
      state_d = ST_IDLE;
      wb_en_d = 1'b1;
      wb_addr_d = mdst_q;
      wb_data_d = mul_prod[DW-1:0];
      carry_d = |mul_prod[2*DW-1:DW];
      zero_d = mul_prod[DW-1:0] == '0;
    end
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wb_en_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      carry_q <= 1'b0;
      zero_q <= 1'b0;
      illegal_q <= 1'b0;
`ifdef EXEC_UNIT_MUL_EN
      mdst_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wb_en_q <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      carry_q <= carry_d;
      zero_q <= zero_d;
      illegal_q <= illegal_d;
`ifdef EXEC_UNIT_MUL_EN
      mdst_q <= mdst_d;
`endif
    end
  end
endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed stimulus checked against an arithmetic reference model every cycle,
// plus literal expectations; exercises MUL or the illegal path depending on EXEC_UNIT_MUL_EN.
module tb_exec_unit;
`ifdef EXEC_UNIT_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, issue_valid = 1'b0, issue_ready;
  logic [2:0] op = '0;
  logic [1:0] dst = '0, wb_addr;
  logic [7:0] opa = '0, opb = '0, wb_data;
  logic wb_en, carry, zero, busy, illegal;
  int n_chk = 0, n_fail = 0;
  // reference model state
  int m_left, m_prod, m_mdst;
  logic m_wb_en, m_carry, m_zero, m_illegal;
  logic [1:0] m_addr;
  logic [7:0] m_data;

  exec_unit dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .op(op), .dst(dst), .opa(opa), .opb(opb), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .carry(carry), .zero(zero), .busy(busy), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    int a, b, r;
    if (!rst_n) begin
      m_left <= 0; m_prod <= 0; m_mdst <= 0;
      m_wb_en <= 0; m_carry <= 0; m_zero <= 0; m_illegal <= 0;
      m_addr <= 0; m_data <= 0;
    end else begin
      m_wb_en <= 0;
      m_illegal <= 0;
      a = int'(opa);
      b = int'(opb);
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_wb_en <= 1; m_addr <= 2'(m_mdst); m_data <= 8'(m_prod % 256);
          m_carry <= (m_prod / 256) != 0; m_zero <= (m_prod % 256) == 0;
        end
      end else if (issue_valid) begin
        r = -1;
        case (op)
          3'd0: begin r = (a + b) % 256; m_carry <= (a + b) > 255; end
          3'd1: begin r = (a - b + 256) % 256; m_carry <= a < b; end
          3'd2: r = a & b;
          3'd3: r = a | b;
          3'd4: r = a ^ b;
          3'd5: r = b;
          3'd6: if (MUL_EN) begin m_left <= 8; m_prod <= a * b; m_mdst <= int'(dst); end
                else m_illegal <= 1;
          default: begin m_zero <= a == b; m_carry <= a < b; end
        endcase
        if (r >= 0) begin
          m_wb_en <= 1; m_addr <= dst; m_data <= 8'(r); m_zero <= r == 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("m_wb_en", 32'(wb_en), 32'(m_wb_en));
    chk("m_wb_addr", 32'(wb_addr), 32'(m_addr));
    chk("m_wb_data", 32'(wb_data), 32'(m_data));
    chk("m_carry", 32'(carry), 32'(m_carry));
    chk("m_zero", 32'(zero), 32'(m_zero));
    chk("m_illegal", 32'(illegal), 32'(m_illegal));
    chk("m_busy", 32'(busy), 32'(m_left > 0));
    chk("m_ready", 32'(issue_ready), 32'(m_left == 0));
  end

  task automatic set_op(input logic [2:0] o, input logic [1:0] d, input logic [7:0] a, input logic [7:0] b);
    issue_valid = 1'b1; op = o; dst = d; opa = a; opb = b;
  endtask

  initial begin
    cyc(); cyc();
    chk("rst_wb_en", 32'(wb_en), 0);
    chk("rst_wb_data", 32'(wb_data), 0);
    chk("rst_ready", 32'(issue_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    cyc();
    set_op(3'd0, 2'd2, 8'hF0, 8'h20); cyc(); issue_valid = 1'b0;
    chk("add_wb_en", 32'(wb_en), 1);
    chk("add_wb_addr", 32'(wb_addr), 2);
    chk("add_wb_data", 32'(wb_data), 32'h10);
    chk("add_carry", 32'(carry), 1);
    chk("add_zero", 32'(zero), 0);
    cyc();
    chk("add_pulse", 32'(wb_en), 0);
    chk("add_hold", 32'(wb_data), 32'h10);
    set_op(3'd7, 2'd1, 8'h05, 8'h05); cyc(); issue_valid = 1'b0;
    chk("cmp_zero", 32'(zero), 1);
    chk("cmp_carry", 32'(carry), 0);
    chk("cmp_wb_en", 32'(wb_en), 0);
    chk("cmp_hold", 32'(wb_data), 32'h10);
    cyc();
    set_op(3'd4, 2'd1, 8'hAA, 8'hFF); cyc();
    chk("xor_data", 32'(wb_data), 32'h55);
    set_op(3'd5, 2'd0, 8'h00, 8'h3C); cyc(); issue_valid = 1'b0;
    chk("mov_data", 32'(wb_data), 32'h3C);
    chk("mov_wb_en", 32'(wb_en), 1);
    set_op(3'd1, 2'd3, 8'h03, 8'h05); cyc();
    chk("sub_data", 32'(wb_data), 32'hFE);
    chk("sub_borrow", 32'(carry), 1);
    set_op(3'd1, 2'd3, 8'h05, 8'h05); cyc();
    chk("sub_zero", 32'(zero), 1);
    set_op(3'd2, 2'd0, 8'hF0, 8'h3C); cyc();
    chk("and_data", 32'(wb_data), 32'h30);
    chk("and_carry_kept", 32'(carry), 0);
    set_op(3'd3, 2'd1, 8'h00, 8'h00); cyc(); issue_valid = 1'b0;
    chk("or_zero", 32'(zero), 1);
    set_op(3'd0, 2'd0, 8'hFF, 8'h01); cyc(); issue_valid = 1'b0;
    chk("add_wrap_carry", 32'(carry), 1);
    if (MUL_EN) begin
      set_op(3'd6, 2'd3, 8'h12, 8'h10); cyc();
      set_op(3'd0, 2'd1, 8'h01, 8'h01);
      for (int i = 0; i < 8; i++) begin
        chk("mul_busy", 32'(busy), 1);
        chk("mul_ready", 32'(issue_ready), 0);
        chk("mul_no_wb", 32'(wb_en), 0);
        if (i == 6) issue_valid = 1'b0;
        if (i < 7) cyc();
      end
      cyc();
      chk("mul_wb_en", 32'(wb_en), 1);
      chk("mul_data", 32'(wb_data), 32'h20);
      chk("mul_carry", 32'(carry), 1);
      chk("mul_addr", 32'(wb_addr), 3);
      chk("mul_done_busy", 32'(busy), 0);
      cyc();
      set_op(3'd6, 2'd2, 8'h07, 8'h09); cyc(); issue_valid = 1'b0;
      cyc(); cyc();
      rst_n = 1'b0; #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_wb_en", 32'(wb_en), 0);
      chk("abort_ready", 32'(issue_ready), 1);
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
        cyc();
        chk("abort_no_wb", 32'(wb_en), 0);
      end
    end else begin
      cyc();
      set_op(3'd6, 2'd3, 8'h12, 8'h10); cyc(); issue_valid = 1'b0;
      chk("ill_pulse", 32'(illegal), 1);
      chk("ill_no_wb", 32'(wb_en), 0);
      chk("ill_carry_kept", 32'(carry), 1);
      chk("ill_busy", 32'(busy), 0);
      cyc();
      chk("ill_one_cycle", 32'(illegal), 0);
      chk("ill_ready", 32'(issue_ready), 1);
      rst_n = 1'b0; #1;
      chk("rst2_carry", 32'(carry), 0);
      cyc();
      rst_n = 1'b1;
    end
    cyc();
    set_op(3'd0, 2'd1, 8'h01, 8'h01); cyc(); issue_valid = 1'b0;
    chk("post_rst_add", 32'(wb_data), 32'h02);
    chk("post_rst_wb_en", 32'(wb_en), 1);
    cyc(); cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
